// File: rtl/double_to_sig16b_if.sv
// Request/result bundle for the binary64 to 16-bit sign-magnitude converter.
// master drives the operand and request strobe; slave returns the registered result.
interface double_to_sig16b_if;
  logic        enable;
  logic [63:0] double;
  logic [15:0] sig16b;
  logic        ready;
  logic        busy;
  logic        sat;

  modport master (
    output enable, double,
    input  sig16b, ready, busy, sat
  );

  modport slave (
    input  enable, double,
    output sig16b, ready, busy, sat
  );
endinterface

// File: rtl/double_to_sig16b.sv
// Converts an IEEE-754 binary64 operand to a saturating 16-bit sign-magnitude
// integer, truncating toward zero with a serial right shift (1..16 cycle latency).
//
// state | meaning
// IDLE  | waiting for enable; result registers hold the last conversion
// SHIFT | shifting the mantissa down; completes when the counter reaches 0
module double_to_sig16b (
  input  logic             clk_operation,
  input  logic             rst,
  double_to_sig16b_if.slave bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state;
  logic [15:0] shreg;
  logic [3:0]  cnt;
  logic        sign;
  logic        sat_pend;

  logic [10:0] exp_b;
  logic        is_sat;
  logic        is_zero;
  logic [3:0]  n_init;
  logic        unused_frac;

  assign exp_b   = bus.double[62:52];
  assign is_sat  = (exp_b == 11'h7FF) || (exp_b >= 11'd1038);
  assign is_zero = (exp_b < 11'd1023);
  // n = 15 - (E - 1023); since 1023 = 15 mod 16 this reduces to 14 - E[3:0] in 4 bits
  assign n_init  = 4'd14 - exp_b[3:0];
  assign unused_frac = ^bus.double[36:0];

  always_ff @(posedge clk_operation) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= 16'h0000;
      cnt        <= 4'd0;
      sign       <= 1'b0;
      sat_pend   <= 1'b0;
      bus.sig16b <= 16'h0000;
      bus.ready  <= 1'b0;
      bus.busy   <= 1'b0;
      bus.sat    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.ready <= 1'b0;
          bus.sat   <= 1'b0;
          if (bus.enable) begin
            sign     <= bus.double[63];
            bus.busy <= 1'b1;
            state    <= SHIFT;
            // saturate and zero reuse the SHIFT completion path with a zero count
            if (is_sat) begin
              shreg    <= 16'h7FFF;
              cnt      <= 4'd0;
              sat_pend <= 1'b1;
            end else if (is_zero) begin
              shreg    <= 16'h0000;
              cnt      <= 4'd0;
              sat_pend <= 1'b0;
            end else begin
              shreg    <= {1'b1, bus.double[51:37]};
              cnt      <= n_init;
              sat_pend <= 1'b0;
            end
          end
        end
        SHIFT: begin
          if (cnt != 4'd0) begin
            shreg <= {1'b0, shreg[15:1]};
            cnt   <= cnt - 4'd1;
          end else begin
            bus.sig16b <= {sign & (|shreg[14:0]), shreg[14:0]};
            bus.ready  <= 1'b1;
            bus.sat    <= sat_pend;
            bus.busy   <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_double_to_sig16b.sv
// Directed bench for double_to_sig16b: expected results are queued when a request
// is driven and checked (value, sat, arrival cycle) when ready pulses.
module tb_double_to_sig16b;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  typedef struct {
    logic [15:0] val;
    logic        s;
    int          at;
  } exp_t;

  exp_t q[$];

  double_to_sig16b_if bus ();

  double_to_sig16b dut (
    .clk_operation (clk),
    .rst           (rst),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every ready pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ready) begin
        if (q.size() == 0) begin
          check("unexpected_ready", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("sig16b", {48'd0, bus.sig16b}, {48'd0, e.val});
          check("sat", {63'd0, bus.sat}, {63'd0, e.s});
          check("ready_cycle", 64'(cyc), 64'(e.at));
        end
      end else begin
        check("sat_without_ready", {63'd0, bus.sat}, 64'd0);
      end
    end
  end

  // Called at a negedge; the request is sampled at the next posedge (T0).
  task automatic send(input logic [63:0] d, input logic [15:0] val, input logic s, input int lat);
    exp_t e;
    e.val = val;
    e.s   = s;
    e.at  = cyc + 1 + lat;
    q.push_back(e);
    bus.enable = 1'b1;
    bus.double = d;
    @(negedge clk);
    bus.enable = 1'b0;
    bus.double = 64'h0;
  endtask

  task automatic wait_done();
    int b;
    b = 0;
    while ((q.size() != 0 || bus.busy) && b < 64) begin
      @(negedge clk);
      b++;
    end
    check("drain_timeout", 64'(b < 64), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    checks     = 0;
    failures   = 0;
    cyc        = 0;
    rst        = 1'b1;
    bus.enable = 1'b0;
    bus.double = 64'h0;
    repeat (3) @(negedge clk);
    check("rst_sig16b", {48'd0, bus.sig16b}, 64'd0);
    check("rst_ready", {63'd0, bus.ready}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_sat", {63'd0, bus.sat}, 64'd0);
    rst = 1'b0;

    // 1.0 at the first edge out of reset, with busy profile T0..T0+15
    send(64'h3FF0000000000000, 16'h0001, 1'b0, 16);
    for (int i = 0; i < 16; i++) begin
      check("busy_1p0", {63'd0, bus.busy}, 64'd1);
      @(negedge clk);
    end
    check("busy_1p0_end", {63'd0, bus.busy}, 64'd0);
    wait_done();

    send(64'hC08F400000000000, 16'h83E8, 1'b0, 7);   wait_done(); // -1000.0
    send(64'h40DFFFC000000000, 16'h7FFF, 1'b0, 2);   wait_done(); // 32767.0
    send(64'h4006000000000000, 16'h0002, 1'b0, 15);  wait_done(); // 2.75
    send(64'h40E3880000000000, 16'h7FFF, 1'b1, 1);   wait_done(); // 40000.0
    send(64'hBFE8000000000000, 16'h0000, 1'b0, 1);   wait_done(); // -0.75
    send(64'h7FF8000000000000, 16'h7FFF, 1'b1, 1);   wait_done(); // NaN
    send(64'hFFF0000000000000, 16'hFFFF, 1'b1, 1);   wait_done(); // -Inf
    send(64'h40E0000000000000, 16'h7FFF, 1'b1, 1);   wait_done(); // 32768.0, k=15
    send(64'h8000000000000000, 16'h0000, 1'b0, 1);   wait_done(); // -0.0
    send(64'h3FF00000001FFFFF, 16'h0001, 1'b0, 16);  wait_done(); // low fraction ignored
    send(64'hC0DFFFC000000000, 16'hFFFF, 1'b0, 2);   wait_done(); // -32767.0

    // enable at T0+3 while busy is ignored
    send(64'h3FF0000000000000, 16'h0001, 1'b0, 16);
    @(negedge clk);
    @(negedge clk);
    bus.enable = 1'b1;
    bus.double = 64'hC08F400000000000;
    @(negedge clk);
    bus.enable = 1'b0;
    bus.double = 64'h0;
    wait_done();
    repeat (20) @(negedge clk);

    // reset at T0+5 aborts the conversion with no ready pulse
    bus.enable = 1'b1;
    bus.double = 64'h3FF0000000000000;
    @(negedge clk);
    bus.enable = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_sig16b", {48'd0, bus.sig16b}, 64'd0);
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_ready", {63'd0, bus.ready}, 64'd0);
    rst = 1'b0;
    send(64'hC08F400000000000, 16'h83E8, 1'b0, 7);
    wait_done();
    repeat (20) @(negedge clk);

    // back-to-back: each new request is driven during the previous ready cycle
    send(64'h40E3880000000000, 16'h7FFF, 1'b1, 1);
    @(negedge clk);
    check("b2b_ready_a", {63'd0, bus.ready}, 64'd1);
    send(64'hBFE8000000000000, 16'h0000, 1'b0, 1);
    @(negedge clk);
    check("b2b_ready_b", {63'd0, bus.ready}, 64'd1);
    send(64'h4006000000000000, 16'h0002, 1'b0, 15);
    wait_done();
    repeat (20) @(negedge clk);

    check("queue_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
